spell_mem_arbiter: RTL and testbench
====================================

# spell_mem_arbiter

Shares the spell core's single-port program/data SRAM between two requesters: the Caravel management core over Wishbone, and the spell stack-CPU's fetch/load/store port. Each access gets one exclusive SRAM cycle. Simultaneous requests are resolved round-robin. The block sits inside the spell user-project wrapper, between the Wishbone slave decode and the SRAM macro.

## Interface
Parameters:
- ADDR_W, 8, SRAM byte-address width (depth 2^ADDR_W bytes)

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  byte selects; only bit 0 is used
- wbs_adr_i  in  32  byte address; bits [ADDR_W-1:0] are used
- wbs_dat_i  in  32  write data; bits [7:0] are used
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  {24'b0, read byte}
- core_req_i  in  1  core request; held stable until core_ack_o
- core_we_i  in  1  core write
- core_addr_i  in  ADDR_W  core address
- core_wdata_i  in  8  core write data
- core_ack_o  out  1  single-cycle acknowledge
- core_rdata_o  out  8  read byte, valid while core_ack_o is high
- mem_en_o  out  1  SRAM enable (registered)
- mem_we_o  out  1  SRAM write enable (registered)
- mem_addr_o  out  ADDR_W  SRAM address (registered)
- mem_wdata_o  out  8  SRAM write data (registered)
- mem_rdata_i  in  8  SRAM read data; valid the cycle after mem_en_o

## Operation
- Request terms:
  - wb_req = wbs_cyc_i & wbs_stb_i.
  - A WB write reaches memory only if wbs_sel_i[0] is set. Otherwise the SRAM cycle runs with mem_we_o=0 and is still acked.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One or more requests: pick the owner, register the mem_* outputs from that owner with mem_en_o=1, go to ACCESS.
- ACCESS: drop mem_en_o and mem_we_o to 0, go to RESP.
- RESP:
  - Assert the owner's ack combinationally from state and owner.
  - Drive core_rdata_o and wbs_dat_o[7:0] straight from mem_rdata_i.
  - Update last_owner and return to IDLE.
- Arbitration:
  - When both request in the same cycle, grant the requester that is not last_owner.
  - last_owner resets to WB, so the core wins the first tie.
- Withdrawn WB strobe:
  - If wb_req is low in RESP, wbs_ack_o is suppressed.
  - A write that already reached memory stays committed.
- The core port never withdraws its request; this is the core's contract.
- A request arriving during ACCESS or RESP is not seen until the next IDLE.
- Reset values:
  - All outputs 0; wbs_dat_o and core_rdata_o read 0 outside RESP.
  - state=IDLE, last_owner=WB.
- Reset mid-operation: return to IDLE with no ack. A write already presented to the SRAM is not rolled back.

## Timing
- Latency: a request seen in IDLE at cycle N gives mem_en_o high in N+1 and ack in N+2. The FSM is back in IDLE at N+3.
- Throughput: one access per 3 cycles.
- Worst-case wait under round-robin: ack at N+5 (one competing transaction ahead).
- Every ack is exactly 1 cycle wide. Both acks are never high in the same cycle.

## Configuration
- Macro: SPELL_ARB_FIXED_PRIO_EN.
- Defined: the core always wins ties and last_owner is unused. WB can starve while the core requests continuously.
- Undefined (default): round-robin as described above.

## Structure
- Package spell_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP)
  - the owner enum (OWN_WB, OWN_CORE)
  - SPELL_MEM_ADDR_W = 8
- Sub-module spell_rr_arb2:
  - Inputs: two request bits and last_owner.
  - Output: the grant.
  - Fixed-priority variant under the macro.

## Test plan
- WB write 0xA5 to address 0x10, then WB read of 0x10:
  - mem_en_o/mem_we_o high at N+1.
  - wbs_ack_o at N+2 for each access.
  - Read returns wbs_dat_o = 0x000000A5.
- Core and WB request in the same cycle after reset:
  - Core acked first, then WB.
  - Repeat the tie: WB is acked first.
- Core requests continuously while WB requests:
  - Acks alternate.
  - WB ack at most 5 cycles after its strobe.
  - With SPELL_ARB_FIXED_PRIO_EN defined, no WB ack occurs.
- WB write with wbs_sel_i = 4'b0010: acked, mem_we_o stays 0, and a read-back returns the old value.
- WB strobe dropped during ACCESS: no wbs_ack_o, FSM back in IDLE at N+3.
- wb_rst_i asserted in ACCESS: next cycle all outputs are 0 and state is IDLE; the pending requester is acked only after re-arbitration.

Source files
------------

// File: rtl/spell_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spell_arb_pkg                                                              |
// | Shared types for the spell SRAM arbiter (FSM states, owner id, widths).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package spell_arb_pkg;

    localparam int SPELL_MEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_WB   = 1'b0,
        OWN_CORE = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_WB) ? OWN_CORE : OWN_WB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spell_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spell_rr_arb2                                                              |
// | Two-way grant: round-robin on ties, or core-first when                     |
// | SPELL_ARB_FIXED_PRIO_EN is defined.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spell_rr_arb2
    import spell_arb_pkg::*;
(
    input  logic   req_wb_i,
    input  logic   req_core_i,
    input  owner_e last_owner_i,
    output owner_e grant_o
);

`ifdef SPELL_ARB_FIXED_PRIO_EN
    logic unused_fixed_prio;
    assign unused_fixed_prio = req_wb_i ^ last_owner_i;

    always_comb begin
        grant_o = req_core_i ? OWN_CORE : OWN_WB;
    end
`else
    // On a tie the previous owner yields, so neither side can starve.
    always_comb begin
        grant_o = OWN_WB;
        if (req_wb_i && req_core_i) begin
            grant_o = other_owner(last_owner_i);
        end else if (req_core_i) begin
            grant_o = OWN_CORE;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/spell_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spell_mem_arbiter                                                          |
// | Shares one single-port SRAM between Wishbone and the spell core; one       |
// | exclusive 3-cycle slot per access. Option macro: SPELL_ARB_FIXED_PRIO_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spell_mem_arbiter
    import spell_arb_pkg::*;
#(
    parameter int ADDR_W = SPELL_MEM_ADDR_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,

    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [7:0]        core_wdata_i,
    output logic              core_ack_o,
    output logic [7:0]        core_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    owner_e            w_grant;
    logic              w_wb_req;
    logic              w_in_resp;
    logic [7:0]        w_rdata;

    logic              unused_wb_bits;
    assign unused_wb_bits = ^{wbs_sel_i[3:1], wbs_adr_i[31:ADDR_W], wbs_dat_i[31:8]};

    assign w_wb_req = wbs_cyc_i & wbs_stb_i;

    spell_rr_arb2 u_arb (
        .req_wb_i     (w_wb_req),
        .req_core_i   (core_req_i),
        .last_owner_i (last_owner_q),
        .grant_o      (w_grant)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (w_wb_req || core_req_i) begin
                    state_d  = ST_ACCESS;
                    owner_d  = w_grant;
                    mem_en_d = 1'b1;
                    if (w_grant == OWN_CORE) begin
                        mem_we_d    = core_we_i;
                        mem_addr_d  = core_addr_i;
                        mem_wdata_d = core_wdata_i;
                    end else begin
                        // A WB write without byte lane 0 still takes a slot, as a read.
                        mem_we_d    = wbs_we_i & wbs_sel_i[0];
                        mem_addr_d  = wbs_adr_i[ADDR_W-1:0];
                        mem_wdata_d = wbs_dat_i[7:0];
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_WB;
            last_owner_q <= OWN_WB;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // SRAM read data lands in RESP; a withdrawn WB strobe loses its ack there.
    assign w_in_resp    = (state_q == ST_RESP);
    assign w_rdata      = w_in_resp ? mem_rdata_i : 8'h00;
    assign core_ack_o   = w_in_resp && (owner_q == OWN_CORE);
    assign wbs_ack_o    = w_in_resp && (owner_q == OWN_WB) && w_wb_req;
    assign core_rdata_o = w_rdata;
    assign wbs_dat_o    = {24'h000000, w_rdata};

    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spell_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spell_mem_arbiter                                                       |
// | Self-checking bench: directed vector table, corner sequences, and random   |
// | traffic against a transaction-timing reference model.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spell_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat_w;
    logic        wbs_ack;
    logic [31:0] wbs_dat_r;
    logic        core_req, core_we;
    logic [7:0]  core_addr, core_wdata;
    logic        core_ack;
    logic [7:0]  core_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  sram [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spell_mem_arbiter #(.ADDR_W(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (wbs_cyc),
        .wbs_stb_i    (wbs_stb),
        .wbs_we_i     (wbs_we),
        .wbs_sel_i    (wbs_sel),
        .wbs_adr_i    (wbs_adr),
        .wbs_dat_i    (wbs_dat_w),
        .wbs_ack_o    (wbs_ack),
        .wbs_dat_o    (wbs_dat_r),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_ack_o   (core_ack),
        .core_rdata_o (core_rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Read-first synchronous SRAM
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= sram[mem_addr];
            if (mem_we) sram[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_core;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        bit          exp_we;
        bit          chk_rd;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0;
        wbs_adr = 32'h0; wbs_dat_w = 32'h0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_en"},    32'(mem_en), 32'h0);
        chk({tag, "_mem_we"},    32'(mem_we), 32'h0);
        chk({tag, "_mem_addr"},  32'(mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, "_wbs_ack"},   32'(wbs_ack), 32'h0);
        chk({tag, "_core_ack"},  32'(core_ack), 32'h0);
        chk({tag, "_wbs_dat"},   wbs_dat_r, 32'h0);
        chk({tag, "_core_rdata"}, 32'(core_rdata), 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        if (v.is_core) begin
            core_req = 1'b1; core_we = v.we; core_addr = v.adr[7:0]; core_wdata = v.dat[7:0];
        end else begin
            wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = v.we; wbs_sel = v.sel;
            wbs_adr = v.adr; wbs_dat_w = v.dat;
        end
        #4; chk({t, "_en_n0"}, 32'(mem_en), 32'h0);
        tick();
        #4;
        chk({t, "_en_n1"}, 32'(mem_en), 32'h1);
        chk({t, "_we_n1"}, 32'(mem_we), 32'(v.exp_we));
        chk({t, "_addr_n1"}, 32'(mem_addr), 32'(v.adr[7:0]));
        if (v.we) chk({t, "_wdata_n1"}, 32'(mem_wdata), 32'(v.dat[7:0]));
        chk({t, "_ack_n1"}, 32'({wbs_ack, core_ack}), 32'h0);
        tick();
        #4;
        chk({t, "_core_ack_n2"}, 32'(core_ack), 32'(v.is_core));
        chk({t, "_wbs_ack_n2"}, 32'(wbs_ack), 32'(!v.is_core));
        chk({t, "_en_n2"}, 32'(mem_en), 32'h0);
        if (v.chk_rd) begin
            if (v.is_core) chk({t, "_core_rdata"}, 32'(core_rdata), 32'(v.exp_rd));
            else           chk({t, "_wbs_dat"}, wbs_dat_r, {24'h0, v.exp_rd});
        end
        tick();
        clear_inputs();
        #4;
        chk({t, "_ack_n3"}, 32'({wbs_ack, core_ack}), 32'h0);
        chk({t, "_en_n3"}, 32'(mem_en), 32'h0);
        tick();
    endtask

    // Both ask in the same idle cycle; each side drops after its own ack.
    task automatic run_tie(input bit core_first, input string t);
        int c_at;
        int w_at;
        c_at = -1; w_at = -1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_sel = 4'h1; wbs_adr = 32'h10;
        for (int i = 0; i < 8; i++) begin
            #4;
            chk({t, "_dual_ack"}, 32'(core_ack & wbs_ack), 32'h0);
            if (core_ack) c_at = i;
            if (wbs_ack) w_at = i;
            tick();
            if (c_at >= 0) core_req = 1'b0;
            if (w_at >= 0) begin wbs_cyc = 1'b0; wbs_stb = 1'b0; end
        end
        chk({t, "_core_ack_cycle"}, 32'(c_at), core_first ? 32'd2 : 32'd5);
        chk({t, "_wb_ack_cycle"},   32'(w_at), core_first ? 32'd5 : 32'd2);
        clear_inputs();
    endtask

    task automatic run_continuous();
        int last_seen;
        int first_wb;
        int wb_acks;
        int cur;
        last_seen = -1; first_wb = -1; wb_acks = 0;
        clear_inputs();
        core_req = 1'b1; core_addr = 8'h20;
        for (int i = 0; i < 30; i++) begin
            if (i == 1) begin
                wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_sel = 4'h1; wbs_adr = 32'h10;
            end
            #4;
            chk("cont_dual_ack", 32'(core_ack & wbs_ack), 32'h0);
            if (wbs_ack) begin
                wb_acks++;
                if (first_wb < 0) first_wb = i;
            end
`ifndef SPELL_ARB_FIXED_PRIO_EN
            if (core_ack || wbs_ack) begin
                cur = wbs_ack ? 0 : 1;
                if (last_seen >= 0) chk("cont_alternation", 32'(cur), 32'(1 - last_seen));
                last_seen = cur;
            end
`endif
            tick();
        end
`ifdef SPELL_ARB_FIXED_PRIO_EN
        chk("cont_wb_starved", 32'(wb_acks), 32'h0);
`else
        chk("cont_wb_first_ack", 32'(first_wb), 32'd5);
        chk("cont_wb_ack_count", 32'(wb_acks), 32'd5);
`endif
    endtask

    task automatic run_random(input int n_cycles);
        int   g;
        bit   m_owner, m_last, m_we;
        logic [7:0] m_addr, m_wdata, m_rd;
        bit   drop_core, drop_wb, wb_on, wb_now, resp, en;
        g = -10; m_last = 1'b0; m_owner = 1'b0; m_we = 1'b0;
        m_addr = 8'h0; m_wdata = 8'h0; m_rd = 8'h0;
        drop_core = 1'b0; drop_wb = 1'b0; wb_on = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = sram[i];
        for (int c = 0; c < n_cycles; c++) begin
            if (drop_core) core_req = 1'b0;
            if (drop_wb) wb_on = 1'b0;
            if (!core_req && $urandom_range(0, 2) == 0) begin
                core_req = 1'b1; core_we = 1'($urandom);
                core_addr = 8'($urandom_range(0, 15)); core_wdata = 8'($urandom);
            end
            if (!wb_on) begin
                if ($urandom_range(0, 2) == 0) begin
                    wb_on = 1'b1; wbs_we = 1'($urandom); wbs_sel = 4'($urandom);
                    wbs_adr = $urandom; wbs_adr[7:4] = 4'h0; wbs_dat_w = $urandom;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                wb_on = 1'b0;
            end
            wbs_stb = wb_on;
            wbs_cyc = wb_on | ($urandom_range(0, 3) == 0);
            wb_now  = wbs_cyc & wbs_stb;
            drop_core = 1'b0; drop_wb = 1'b0;

            en   = (c == g + 1);
            resp = (c == g + 2);
            #4;
            chk("rnd_mem_en", 32'(mem_en), 32'(en));
            chk("rnd_mem_we", 32'(mem_we), 32'(en && m_we));
            if (en) begin
                chk("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("rnd_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            chk("rnd_core_ack", 32'(core_ack), 32'(resp && m_owner));
            chk("rnd_wbs_ack", 32'(wbs_ack), 32'(resp && !m_owner && wb_now));
            chk("rnd_core_rdata", 32'(core_rdata), resp ? 32'(m_rd) : 32'h0);
            chk("rnd_wbs_dat", wbs_dat_r, resp ? {24'h0, m_rd} : 32'h0);

            if (resp) begin
                m_last = m_owner;
                drop_core = m_owner;
                drop_wb = !m_owner;
            end
            if (c >= g + 3 && (wb_now || core_req)) begin
`ifdef SPELL_ARB_FIXED_PRIO_EN
                m_owner = core_req;
`else
                m_owner = (wb_now && core_req) ? !m_last : core_req;
`endif
                if (m_owner) begin
                    m_we = core_we; m_addr = core_addr; m_wdata = core_wdata;
                end else begin
                    m_we = wbs_we & wbs_sel[0]; m_addr = wbs_adr[7:0]; m_wdata = wbs_dat_w[7:0];
                end
                m_rd = ref_mem[m_addr];
                if (m_we) ref_mem[m_addr] = m_wdata;
                g = c;
            end
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'h1, 32'h0000_0010, 32'h0000_00A5, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 4'h1, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 4'h2, 32'h0000_0010, 32'h0000_003C, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 4'h1, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 8'hA5};
        vecs[4] = '{1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0000_005A, 1'b1, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 4'h1, 32'h0000_0020, 32'h0000_0000, 1'b0, 1'b1, 8'h5A};
        vecs[6] = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 1'b0, 1'b1, 8'hA5};
        vecs[7] = '{1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'hDEAD_BEC3, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 4'hE, 32'h0000_00FF, 32'h0000_0011, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{1'b1, 1'b0, 4'h0, 32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 8'hC3};

        clear_inputs();
        do_reset();
        #4;
        chk_quiet("reset");
        tick();

        // last_owner resets to WB, so the core takes the first tie.
        run_tie(1'b1, "tie1");

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // The table ends on a core access, so the next tie goes to WB.
`ifdef SPELL_ARB_FIXED_PRIO_EN
        run_tie(1'b1, "tie2");
`else
        run_tie(1'b0, "tie2");
`endif

        // WB strobe withdrawn during ACCESS; core request arrives in ACCESS.
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_sel = 4'h1; wbs_adr = 32'h10;
        #4; tick();
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
        #4; chk("drop_en_n1", 32'(mem_en), 32'h1); tick();
        #4; chk("drop_wbs_ack_n2", 32'(wbs_ack), 32'h0);
        chk("drop_core_ack_n2", 32'(core_ack), 32'h0); tick();
        #4; chk("drop_en_n3", 32'(mem_en), 32'h0); tick();
        #4; chk("drop_en_n4", 32'(mem_en), 32'h1);
        chk("drop_addr_n4", 32'(mem_addr), 32'h20); tick();
        #4; chk("drop_core_ack_n5", 32'(core_ack), 32'h1); tick();
        clear_inputs();
        #4; tick();

        // Reset pulse while a WB read sits in ACCESS.
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_sel = 4'h1; wbs_adr = 32'h10;
        #4; tick();
        rst = 1'b1;
        #4; chk("rst_en_n1", 32'(mem_en), 32'h1); tick();
        rst = 1'b0;
        #4; chk_quiet("rst_n2"); tick();
        #4; chk("rst_en_n3", 32'(mem_en), 32'h1);
        chk("rst_addr_n3", 32'(mem_addr), 32'h10);
        chk("rst_wbs_ack_n3", 32'(wbs_ack), 32'h0); tick();
        #4; chk("rst_wbs_ack_n4", 32'(wbs_ack), 32'h1);
        chk("rst_wbs_dat_n4", wbs_dat_r, 32'h0000_00A5); tick();
        clear_inputs();
        #4; tick();

        run_continuous();
        do_reset();

        run_random(800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
